screen_scanner: RTL and testbench

SCREEN_SCANNER -- requirements
Module: screen_scanner

---
 rtl/screen_scanner.sv | 142 ++++++++++++++
 tb/tb_screen_scanner.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/screen_scanner.sv
// screen_scanner: walks a ROWS x COLS text buffer in row-major order and
// streams each character over a valid/ready port, optionally appending an
// end-of-row character after every row.
module screen_scanner #(
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           ROWS       = 4,
    parameter int unsigned           COLS       = 32,
    parameter int unsigned           EMIT_EOL   = 1,
    parameter logic [DATA_WIDTH-1:0] EOL_CHAR   = 8'h0A,
    localparam int unsigned          RW         = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned          CW         = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic [RW-1:0]         r_row,
    output logic [CW-1:0]         r_col,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_SEND    = 3'd3;
    localparam logic [2:0] S_EOL     = 3'd4;

    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    logic [2:0]            state_q, state_d;
    logic [RW-1:0]         row_q,   row_d;
    logic [CW-1:0]         col_q,   col_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic                  done_q,  done_d;

    // Next-state logic: scan sequencing, address stepping and abort override.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        data_d  = data_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A start coinciding with the done pulse is not a new request.
                if (start && !done_q) begin
                    state_d = S_FETCH;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            S_FETCH: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                data_d  = rd_data;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (out_ready) begin
                    if (col_q != COL_LAST) begin
                        col_d   = col_q + 1'b1;
                        state_d = S_FETCH;
                    end else if (EMIT_EOL != 0) begin
                        data_d  = EOL_CHAR;
                        state_d = S_EOL;
                    end else if (row_q != ROW_LAST) begin
                        row_d   = row_q + 1'b1;
                        col_d   = '0;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_EOL: begin
                if (out_ready) begin
                    if (row_q != ROW_LAST) begin
                        row_d   = row_q + 1'b1;
                        col_d   = '0;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Abort outranks any transfer decided above and suppresses done.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            row_d   = '0;
            col_d   = '0;
            done_d  = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    // Output decode from registered state.
    always_comb begin
        r_row     = row_q;
        r_col     = col_q;
        out_data  = data_q;
        out_valid = (state_q == S_SEND) || (state_q == S_EOL);
        busy      = (state_q != S_IDLE);
        done      = done_q;
        out_last  = 1'b0;
        if (EMIT_EOL != 0) begin
            out_last = (state_q == S_EOL) && (row_q == ROW_LAST);
        end else begin
            out_last = (state_q == S_SEND) && (row_q == ROW_LAST) && (col_q == COL_LAST);
        end
    end

endmodule

// File: tb/tb_screen_scanner.sv
// Directed bench for screen_scanner: default 4x32 with EOL, and a 3x5
// instance without EOL.
module tb_screen_scanner;

    logic       clk = 1'b0;
    logic       rst_n;

    // Default-configuration instance
    logic       start, abort, out_ready;
    logic [1:0] r_row;
    logic [4:0] r_col;
    logic [7:0] rd_data, out_data;
    logic       out_valid, out_last, busy, done;

    // 3x5 instance, no EOL
    logic       start2, abort2, out_ready2;
    logic [1:0] r_row2;
    logic [2:0] r_col2;
    logic [7:0] rd_data2, out_data2;
    logic       out_valid2, out_last2, busy2, done2;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    screen_scanner dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .r_row(r_row), .r_col(r_col), .rd_data(rd_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done)
    );

    screen_scanner #(.DATA_WIDTH(8), .ROWS(3), .COLS(5), .EMIT_EOL(0), .EOL_CHAR(8'h0A)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
        .r_row(r_row2), .r_col(r_col2), .rd_data(rd_data2),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_last(out_last2), .busy(busy2), .done(done2)
    );

    // Synchronous RAM models: one-cycle read latency
    always @(posedge clk) begin
        rd_data  <= 8'(r_row * 32 + r_col);
        rd_data2 <= 8'(r_row2 * 16 + r_col2 + 1);
    end

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;            // reset must win over start
        abort = 1'b0;
        out_ready = 1'b1;
        start2 = 1'b1;
        abort2 = 1'b0;
        out_ready2 = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if ({r_row, r_col, out_data, out_valid, out_last, busy, done} !== 19'd0) begin
            mismatched++;
            $display("FAIL reset_dut: got row=%0d col=%0d data=%0h v=%b l=%b busy=%b done=%b expected all 0",
                     r_row, r_col, out_data, out_valid, out_last, busy, done);
        end
        compared++;
        if ({r_row2, r_col2, out_data2, out_valid2, out_last2, busy2, done2} !== 17'd0) begin
            mismatched++;
            $display("FAIL reset_dut2: got row=%0d col=%0d data=%0h v=%b l=%b busy=%b done=%b expected all 0",
                     r_row2, r_col2, out_data2, out_valid2, out_last2, busy2, done2);
        end
        start = 1'b0;
        start2 = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_full_scan(input bit rand_ready);
        int k = 0;
        bit prev_final = 1'b0;
        bit hold = 1'b0;
        bit seen_done = 1'b0;
        logic [7:0] held = '0;
        logic [7:0] exp;
        start = 1'b1;
        for (int cyc = 0; cyc < 4000 && !seen_done; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (hold) begin
                compared++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    mismatched++;
                    $display("FAIL stall_stable: got v=%b data=%0h expected v=1 data=%0h", out_valid, out_data, held);
                end
            end
            if (done || prev_final) begin
                compared++;
                if (done !== prev_final) begin
                    mismatched++;
                    $display("FAIL done_timing: got done=%b expected %b at transfer %0d", done, prev_final, k);
                end
            end
            if (done) begin
                seen_done = 1'b1;
                compared++;
                if (busy !== 1'b0) begin
                    mismatched++;
                    $display("FAIL done_busy: got busy=%b expected 0", busy);
                end
                compared++;
                if (k != 132) begin
                    mismatched++;
                    $display("FAIL transfer_count: got %0d expected 132", k);
                end
                start = 1'b1;    // start in the done cycle must be ignored
            end
            prev_final = 1'b0;
            if (!seen_done) begin
                out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (out_valid && out_ready) begin
                    exp = (k % 33 == 32) ? 8'h0A : 8'((k / 33) * 32 + (k % 33));
                    compared++;
                    if (out_data !== exp) begin
                        mismatched++;
                        $display("FAIL scan_data[%0d]: got %0h expected %0h", k, out_data, exp);
                    end
                    compared++;
                    if (out_last !== (k == 131)) begin
                        mismatched++;
                        $display("FAIL scan_last[%0d]: got %b expected %b", k, out_last, (k == 131));
                    end
                    if (k == 131) prev_final = 1'b1;
                    k++;
                    hold = 1'b0;
                end else begin
                    hold = out_valid;
                    held = out_data;
                end
                if (!rand_ready && k == 50) start = 1'b1;   // start while busy
            end
        end
        if (!seen_done) begin
            mismatched++;
            $display("FAIL scan_timeout: got no done expected done after 132 transfers");
        end
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        compared++;
        if (done !== 1'b0) begin
            mismatched++;
            $display("FAIL done_width: got done=%b expected 0", done);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            compared++;
            if (busy !== 1'b0 || out_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL no_restart: got busy=%b v=%b expected 0 0", busy, out_valid);
            end
        end
    endtask

    task automatic test_no_eol();
        int k = 0;
        bit prev_final = 1'b0;
        bit seen_done = 1'b0;
        logic [7:0] exp;
        out_ready2 = 1'b1;
        start2 = 1'b1;
        for (int cyc = 0; cyc < 500 && !seen_done; cyc++) begin
            @(negedge clk);
            start2 = 1'b0;
            compared++;
            if (r_row2 > 2'd2 || r_col2 > 3'd4) begin
                mismatched++;
                $display("FAIL addr_range: got row=%0d col=%0d expected row<=2 col<=4", r_row2, r_col2);
            end
            if (done2 || prev_final) begin
                compared++;
                if (done2 !== prev_final) begin
                    mismatched++;
                    $display("FAIL noeol_done: got done=%b expected %b", done2, prev_final);
                end
            end
            if (done2) begin
                seen_done = 1'b1;
                compared++;
                if (k != 15) begin
                    mismatched++;
                    $display("FAIL noeol_count: got %0d expected 15", k);
                end
            end
            prev_final = 1'b0;
            if (out_valid2 && out_ready2) begin
                exp = 8'((k / 5) * 16 + (k % 5) + 1);
                compared++;
                if (out_data2 !== exp) begin
                    mismatched++;
                    $display("FAIL noeol_data[%0d]: got %0h expected %0h", k, out_data2, exp);
                end
                compared++;
                if (out_last2 !== (k == 14)) begin
                    mismatched++;
                    $display("FAIL noeol_last[%0d]: got %b expected %b", k, out_last2, (k == 14));
                end
                if (k == 14) prev_final = 1'b1;
                k++;
            end
        end
        if (!seen_done) begin
            mismatched++;
            $display("FAIL noeol_timeout: got no done expected done after 15 transfers");
        end
    endtask

    task automatic test_abort();
        bit found = 1'b0;
        out_ready = 1'b1;
        // start and abort together in IDLE: start wins
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL start_over_abort: got busy=%b expected 1", busy);
        end
        for (int cyc = 0; cyc < 1000 && !found; cyc++) begin
            @(negedge clk);
            if (out_valid && r_row == 2'd1 && r_col == 5'd7) found = 1'b1;
        end
        if (!found) begin
            mismatched++;
            $display("FAIL abort_reach: got no SEND at (1,7) expected one");
        end
        compared++;
        if (out_data !== 8'd39) begin
            mismatched++;
            $display("FAIL abort_cell: got %0h expected 27", out_data);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        compared++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_idle: got v=%b busy=%b done=%b expected 0 0 0", out_valid, busy, done);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            compared++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                mismatched++;
                $display("FAIL abort_nodone: got done=%b busy=%b expected 0 0", done, busy);
            end
        end
        // abort in IDLE has no effect
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        compared++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_in_idle: got busy=%b done=%b expected 0 0", busy, done);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int cyc = 0; cyc < 10 && !found; cyc++) begin
            @(negedge clk);
            if (out_valid) found = 1'b1;
        end
        compared++;
        if (!found || r_row !== 2'd0 || r_col !== 5'd0 || out_data !== 8'd0) begin
            mismatched++;
            $display("FAIL restart_origin: got v=%b row=%0d col=%0d data=%0h expected 1 0 0 0",
                     found, r_row, r_col, out_data);
        end
    endtask

    task automatic test_reset_mid_scan();
        bit found = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 1000 && !found; cyc++) begin
            @(negedge clk);
            if (busy && !out_valid && r_row == 2'd2 && r_col == 5'd10) found = 1'b1;
        end
        if (!found) begin
            mismatched++;
            $display("FAIL reset_reach: got no FETCH at (2,10) expected one");
        end
        @(negedge clk);              // CAPTURE of (2,10)
        compared++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL capture_phase: got v=%b busy=%b expected 0 1", out_valid, busy);
        end
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        compared++;
        if ({r_row, r_col, out_data, out_valid, out_last, busy, done} !== 19'd0) begin
            mismatched++;
            $display("FAIL reset_mid: got row=%0d col=%0d data=%0h v=%b l=%b busy=%b done=%b expected all 0",
                     r_row, r_col, out_data, out_valid, out_last, busy, done);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            compared++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_nodone: got done=%b busy=%b expected 0 0", done, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_scan(1'b0);
        test_full_scan(1'b1);
        test_no_eol();
        test_abort();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
